video_timing_ctrl: RTL and testbench

- Generates the raster timing that sequences the DVI datapath: hsync, vsync, data-enable, pixel coordinates, and a lead-time pixel request for the upstream pixel source.
- Runs in the pixel clock domain (25.2 MHz for 640x480@60) and feeds the TMDS encoders in dvi_top.
- Start/stop FSM guarantees the sink only ever sees whole frames.

---
 rtl/video_timing_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator for the DVI datapath.
// Produces hsync/vsync/de, pixel coordinates, first-pixel pulses and a
// lead-time pixel request. A start/stop FSM parks the counters at the
// frame-end point so the sink only ever sees whole frames.
// Optional build macro VIDEO_TIMING_PATTERN_EN adds a 24-bit colour-bar
// output rgb_o aligned with de_o.
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int REQ_LEAD = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  output logic                        busy_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        de_o,
  output logic [$clog2(H_ACTIVE)-1:0] x_o,
  output logic [$clog2(V_ACTIVE)-1:0] y_o,
  output logic                        frame_start_o,
  output logic                        line_start_o,
  output logic                        req_o
`ifdef VIDEO_TIMING_PATTERN_EN
  ,
  output logic [23:0]                 rgb_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_PARK = HW'(H_TOTAL - REQ_LEAD - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_cnt_reg, h_cnt_next;
  logic [VW-1:0]   v_cnt_reg, v_cnt_next;
  logic            at_park;
  logic            advance;
  logic            running;
  logic [HW:0]     h_sum;
  logic [HW-1:0]   h_ahead;
  logic [VW-1:0]   v_ahead;
  logic            de_next, hs_act, vs_act, req_next, fs_next, ls_next;

  assign at_park = (h_cnt_reg == H_PARK) && (v_cnt_reg == V_LAST);
  assign running = (state_reg != IDLE);

  // Next-state logic: stopping is only allowed at the frame-end park point.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable_i) state_next = RUN;
      RUN:     if (!enable_i) state_next = at_park ? IDLE : DRAIN;
      DRAIN: begin
        if (enable_i)     state_next = RUN;
        else if (at_park) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters only move while the FSM stays active, so they freeze at the park point.
  assign advance = running && (state_next != IDLE);

  // Raster counter increment with line and frame wrap.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (advance) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
      end else begin
        h_cnt_next = h_cnt_reg + HW'(1);
      end
    end
  end

  // Position REQ_LEAD clocks ahead, wrapping into the next line or frame.
  always_comb begin
    h_sum   = {1'b0, h_cnt_reg} + (HW+1)'(REQ_LEAD);
    h_ahead = h_sum[HW-1:0];
    v_ahead = v_cnt_reg;
    if (h_sum > {1'b0, H_LAST}) begin
      h_ahead = HW'(h_sum - (HW+1)'(H_TOTAL));
      v_ahead = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
    end
  end

  // Decode the current counter position into output values; all inactive in IDLE.
  always_comb begin
    de_next  = running && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    hs_act   = running && (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
    vs_act   = running && (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
    req_next = running && (h_ahead < H_ACT) && (v_ahead < V_ACT);
    fs_next  = running && (h_cnt_reg == '0) && (v_cnt_reg == '0);
    ls_next  = running && (h_cnt_reg == '0) && (v_cnt_reg < V_ACT);
  end

  // FSM state and raster counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      h_cnt_reg <= H_PARK;
      v_cnt_reg <= V_LAST;
    end else begin
      state_reg <= state_next;
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Registered timing outputs, one clock behind the counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o        <= 1'b0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      frame_start_o <= 1'b0;
      line_start_o  <= 1'b0;
      req_o         <= 1'b0;
    end else begin
      busy_o        <= (state_next != IDLE);
      hsync_o       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= vs_act ? SYNC_POL : ~SYNC_POL;
      de_o          <= de_next;
      x_o           <= running ? XW'(h_cnt_reg) : '0;
      y_o           <= running ? YW'(v_cnt_reg) : '0;
      frame_start_o <= fs_next;
      line_start_o  <= ls_next;
      req_o         <= req_next;
    end
  end

`ifdef VIDEO_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;

  // Colour-bar lookup from the current column.
  always_comb begin
    bar_idx = 3'(h_cnt_reg / HW'(BAR_W));
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Pattern output registered alongside de_o, blanked outside active video.
  always_ff @(posedge clk_i) begin
    if (rst_i) rgb_o <= '0;
    else       rgb_o <= de_next ? bar_rgb : 24'h000000;
  end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Testbench for video_timing_ctrl using a reduced raster (24x13, 312 clocks
// per frame). A segment table drives rst/enable; a position model pushes the
// expected outputs per clock into a scoreboard queue that is popped and
// compared on the falling edge. A second instance with REQ_LEAD=4 checks the
// req/de lead relation; colour bars are checked when the pattern build is on.
module tb_video_timing_ctrl;

  localparam int TB_HA = 16, TB_HFP = 2, TB_HS = 3, TB_HBP = 3;
  localparam int TB_VA = 8,  TB_VFP = 1, TB_VS = 2, TB_VBP = 2;
  localparam int TB_HT = TB_HA + TB_HFP + TB_HS + TB_HBP;
  localparam int TB_VT = TB_VA + TB_VFP + TB_VS + TB_VBP;
  localparam int TB_F  = TB_HT * TB_VT;
  localparam int LEAD  = 2;
  localparam bit TB_POL = 1'b0;
  localparam int NSEG  = 13;

  logic clk, rst, en;
  logic busy, hs, vs, de, fs, ls, req;
  logic [3:0] x;
  logic [2:0] y;
  logic busy4, hs4, vs4, de4, fs4, ls4, req4;
  logic [3:0] x4;
  logic [2:0] y4;
`ifdef VIDEO_TIMING_PATTERN_EN
  logic [23:0] rgb, rgb4;
`endif

  video_timing_ctrl #(
    .H_ACTIVE(TB_HA), .H_FP(TB_HFP), .H_SYNC(TB_HS), .H_BP(TB_HBP),
    .V_ACTIVE(TB_VA), .V_FP(TB_VFP), .V_SYNC(TB_VS), .V_BP(TB_VBP),
    .SYNC_POL(TB_POL), .REQ_LEAD(LEAD)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .busy_o(busy),
    .hsync_o(hs), .vsync_o(vs), .de_o(de), .x_o(x), .y_o(y),
    .frame_start_o(fs), .line_start_o(ls), .req_o(req)
`ifdef VIDEO_TIMING_PATTERN_EN
    , .rgb_o(rgb)
`endif
  );

  video_timing_ctrl #(
    .H_ACTIVE(TB_HA), .H_FP(TB_HFP), .H_SYNC(TB_HS), .H_BP(TB_HBP),
    .V_ACTIVE(TB_VA), .V_FP(TB_VFP), .V_SYNC(TB_VS), .V_BP(TB_VBP),
    .SYNC_POL(TB_POL), .REQ_LEAD(4)
  ) u_dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .busy_o(busy4),
    .hsync_o(hs4), .vsync_o(vs4), .de_o(de4), .x_o(x4), .y_o(y4),
    .frame_start_o(fs4), .line_start_o(ls4), .req_o(req4)
`ifdef VIDEO_TIMING_PATTERN_EN
    , .rgb_o(rgb4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic en;
    int   ncyc;
    int   exp_fs;
    int   exp_de;
  } seg_t;

  typedef struct {
    logic de, hs, vs, req, fs, ls, busy, xyv;
    int   x, y, seg;
  } exp_t;

  seg_t segs [NSEG];
  exp_t sb_q [$];
  int   obs_fs [NSEG];
  int   obs_de [NSEG];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   m_run = 1'b0;
  int   m_q = 0;

  // Position model: expected outputs for the edge about to sample rst/en.
  task automatic push_expected(input int s);
    exp_t e;
    int pm, h, v, pr;
    e.de = 0; e.hs = ~TB_POL; e.vs = ~TB_POL; e.req = 0; e.fs = 0; e.ls = 0;
    e.busy = 0; e.xyv = 1; e.x = 0; e.y = 0; e.seg = s;
    if (rst) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      e.busy = en;
      if (en) begin
        m_run = 1'b1;
        m_q = -LEAD - 2;
      end
    end else begin
      m_q++;
      pm = ((m_q % TB_F) + TB_F) % TB_F;
      h = pm % TB_HT;
      v = pm / TB_HT;
      pr = (pm + LEAD) % TB_F;
      e.de  = (h < TB_HA) && (v < TB_VA);
      e.hs  = (h >= TB_HA + TB_HFP && h < TB_HA + TB_HFP + TB_HS) ? TB_POL : ~TB_POL;
      e.vs  = (v >= TB_VA + TB_VFP && v < TB_VA + TB_VFP + TB_VS) ? TB_POL : ~TB_POL;
      e.req = ((pr % TB_HT) < TB_HA) && ((pr / TB_HT) < TB_VA);
      e.fs  = (pm == 0);
      e.ls  = (h == 0) && (v < TB_VA);
      e.x = h; e.y = v; e.xyv = e.de;
      e.busy = !(!en && pm == TB_F - LEAD - 1);
      if (!e.busy) m_run = 1'b0;
    end
    sb_q.push_back(e);
  endtask

  // Stimulus driver: walks the segment table, then reports.
  initial begin
    segs[0]  = '{1'b1, 1'b0,   4, 0,   0};  // reset
    segs[1]  = '{1'b0, 1'b1,   5, 1,   1};  // start: frame_start on clock 5
    segs[2]  = '{1'b0, 1'b1, 624, 2, 256};  // two full frames
    segs[3]  = '{1'b0, 1'b0, 400, 0, 127};  // stop mid-frame, drain to park
    segs[4]  = '{1'b0, 1'b1, 100, 1,  64};  // restart
    segs[5]  = '{1'b0, 1'b0,  30, 0,  22};  // drop enable (drain)
    segs[6]  = '{1'b0, 1'b1, 400, 1, 170};  // re-raise during drain, no gap
    segs[7]  = '{1'b1, 1'b1,   1, 0,   0};  // reset mid-frame, enable high
    segs[8]  = '{1'b0, 1'b1,  10, 1,   6};  // restart after reset release
    segs[9]  = '{1'b0, 1'b0, 320, 0, 122};  // drain to idle
    segs[10] = '{1'b0, 1'b0,   5, 0,   0};  // idle
    segs[11] = '{1'b0, 1'b1,   1, 0,   0};  // one-clock enable
    segs[12] = '{1'b0, 1'b0,  10, 0,   0};  // dropped at park point
    for (int s = 0; s < NSEG; s++) begin
      obs_fs[s] = 0;
      obs_de[s] = 0;
    end
    rst = 1'b1;
    en  = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      for (int k = 0; k < segs[s].ncyc; k++) begin
        rst = segs[s].rst;
        en  = segs[s].en;
        push_expected(s);
        @(posedge clk);
        #2;
      end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d required=0", sb_q.size());
    end
    for (int s = 0; s < NSEG; s++) begin
      checks++;
      if (obs_fs[s] != segs[s].exp_fs) begin
        failures++;
        $display("FAIL seg_fs_count seg=%0d got=%0d required=%0d", s, obs_fs[s], segs[s].exp_fs);
      end
      checks++;
      if (obs_de[s] != segs[s].exp_de) begin
        failures++;
        $display("FAIL seg_de_count seg=%0d got=%0d required=%0d", s, obs_de[s], segs[s].exp_de);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Checker: scoreboard pop, frame period, REQ_LEAD=4 lead relation, colour bars.
  initial begin
    exp_t e;
    bit ok;
    int last_fs = -1;
    int cool = 0;
    int nsamp = 0;
    logic [3:0] req4_hist = '0;
`ifdef VIDEO_TIMING_PATTERN_EN
    logic [23:0] bars [8];
    logic [23:0] exp_rgb;
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
`endif
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        obs_fs[e.seg] += int'(fs);
        obs_de[e.seg] += int'(de);
        ok = (de === e.de) && (hs === e.hs) && (vs === e.vs) && (req === e.req) &&
             (fs === e.fs) && (ls === e.ls) && (busy === e.busy) &&
             (!e.xyv || (int'(x) == e.x && int'(y) == e.y));
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL cycle seg=%0d cyc=%0d got de=%b hs=%b vs=%b req=%b fs=%b ls=%b busy=%b x=%0d y=%0d required de=%b hs=%b vs=%b req=%b fs=%b ls=%b busy=%b x=%0d y=%0d",
                   e.seg, cyc, de, hs, vs, req, fs, ls, busy, x, y,
                   e.de, e.hs, e.vs, e.req, e.fs, e.ls, e.busy, e.x, e.y);
        end
      end

      // Frame period while the controller stays continuously busy.
      if (rst || !busy) begin
        last_fs = -1;
      end else if (fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != TB_F) begin
            failures++;
            $display("FAIL frame_period got=%0d required=%0d", cyc - last_fs, TB_F);
          end
        end
        last_fs = cyc;
      end

      // Second instance: req_o must equal de_o four clocks later.
      if (rst) cool = 5;
      else if (cool > 0) cool--;
      nsamp++;
      if (cool == 0 && nsamp > 4) begin
        checks++;
        if (de4 !== req4_hist[3]) begin
          failures++;
          $display("FAIL req_lead4 cyc=%0d de=%b req_4_before=%b", cyc, de4, req4_hist[3]);
        end
      end
      req4_hist = {req4_hist[2:0], req4};

`ifdef VIDEO_TIMING_PATTERN_EN
      exp_rgb = de ? bars[int'(x) / (TB_HA / 8)] : 24'h000000;
      checks++;
      if (rgb !== exp_rgb) begin
        failures++;
        $display("FAIL rgb cyc=%0d x=%0d got=%h required=%h", cyc, x, rgb, exp_rgb);
      end
`endif
    end
  end

endmodule
